cic_decimator: RTL

CIC_DECIMATOR -- requirements
Module: cic_decimator

---
 rtl/cic_pkg.sv | 20 ++
 rtl/cic_decimator_if.sv | 28 ++
 rtl/cic_comb_stage.sv | 25 ++
 rtl/cic_decimator.sv | 139 +++++++++++++
 4 files changed

// File: rtl/cic_pkg.sv
// Shared defaults, ratio-select type and width helpers for the CIC decimator.
package cic_pkg;

  localparam int ORDER_DEF    = 2;
  localparam int DEC_LOG2_DEF = 9;
  localparam int OUT_W_DEF    = 12;

  typedef logic [1:0] dec_sel_t;

  function automatic int acc_w(input int order, input int dec_log2);
    return order * dec_log2 + 1;
  endfunction

  // Right shift that maps a full-scale comb result onto OUT_W bits at ratio 2^(dec_log2-sel).
  function automatic int shift_amt(input int order, input int dec_log2, input int out_w,
                                   input dec_sel_t sel);
    return order * (dec_log2 - int'(sel)) - out_w;
  endfunction

endpackage

// File: rtl/cic_decimator_if.sv
// Decimated-sample output channel with valid/ready handshake and overrun flag.
interface cic_decimator_if
  import cic_pkg::*;
#(
  parameter int OUT_W = OUT_W_DEF
);
  logic [OUT_W-1:0] data_out;
  logic             new_data;
  logic             data_valid;
  logic             data_ready;
  logic             overrun;

  modport master (
    output data_out,
    output new_data,
    output data_valid,
    output overrun,
    input  data_ready
  );

  modport slave (
    input  data_out,
    input  new_data,
    input  data_valid,
    input  overrun,
    output data_ready
  );
endinterface

// File: rtl/cic_comb_stage.sv
// One comb section, differential delay 1: y = x - x_prev, delay memory updated on each frame strobe.
module cic_comb_stage #(
  parameter int W = 19
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] x_i,
  output logic [W-1:0] y_o
);
  logic [W-1:0] dly_q;

  assign y_o = x_i - dly_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dly_q <= '0;
    end else if (clr_i) begin
      dly_q <= '0;
    end else if (en_i) begin
      dly_q <= x_i;
    end
  end
endmodule

// File: rtl/cic_decimator.sv
// CIC decimator for a 1-bit modulator stream: ORDER integrators at the input rate,
// ORDER combs at the frame rate, then scale/saturate into a valid/ready output register.
module cic_decimator
  import cic_pkg::*;
#(
  parameter int ORDER    = ORDER_DEF,
  parameter int DEC_LOG2 = DEC_LOG2_DEF,
  parameter int OUT_W    = OUT_W_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            data_in,
  input  logic            en,
  input  dec_sel_t        dec_sel,
  cic_decimator_if.master out_if
);
  localparam int ACC_W = acc_w(ORDER, DEC_LOG2);

  if (ORDER < 1 || ORDER > 4) begin : g_bad_order
    $error("cic_decimator: ORDER must lie in 1..4");
  end
  if (ORDER * (DEC_LOG2 - 3) < OUT_W) begin : g_bad_width
    $error("cic_decimator: ORDER*(DEC_LOG2-3) must be >= OUT_W");
  end

  function automatic logic [DEC_LOG2-1:0] last_count(input dec_sel_t sel);
    return DEC_LOG2'((1 << (DEC_LOG2 - int'(sel))) - 1);
  endfunction

  function automatic logic [OUT_W-1:0] sat_out(input logic [ACC_W-1:0] v, input dec_sel_t sel);
    logic [ACC_W-1:0] s;
    s = v >> shift_amt(ORDER, DEC_LOG2, OUT_W, sel);
    if (|(s >> OUT_W)) return '1;
    return s[OUT_W-1:0];
  endfunction

  logic [ACC_W-1:0]    integ_q [ORDER];
  logic [ACC_W-1:0]    integ_d [ORDER];
  logic [ACC_W-1:0]    comb_x  [ORDER+1];
  logic [DEC_LOG2-1:0] cnt_q, cnt_d;
  logic [2:0]          settle_q, settle_d;
  dec_sel_t            dec_q, sel_eff;
  logic                init_q;
  logic                wrap, resel;
  logic                vld_p0_q, dlv_p0_q, vld_p1_q;
  logic [ACC_W-1:0]    comb_p1_q;
  logic [OUT_W-1:0]    data_q;
  logic                new_q, valid_q, ovr_q;

  // Until the first clock after reset the live dec_sel stands in for the latched copy.
  always_comb begin
    sel_eff  = init_q ? dec_q : dec_sel;
    wrap     = en && (cnt_q == last_count(sel_eff));
    resel    = wrap && (dec_sel != sel_eff);
    cnt_d    = cnt_q;
    settle_d = settle_q;
    for (int k = 0; k < ORDER; k++) integ_d[k] = integ_q[k];
    if (resel) begin
      cnt_d    = '0;
      settle_d = '0;
      for (int k = 0; k < ORDER; k++) integ_d[k] = '0;
    end else if (en) begin
      cnt_d      = wrap ? '0 : cnt_q + 1'b1;
      integ_d[0] = integ_q[0] + ACC_W'(data_in);
      for (int k = 1; k < ORDER; k++) integ_d[k] = integ_q[k] + integ_q[k-1];
      if (wrap && settle_q != 3'(ORDER)) settle_d = settle_q + 3'd1;
    end
  end

  // Stage p0: integrators, sample counter, settle count, frame-end strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < ORDER; k++) integ_q[k] <= '0;
      cnt_q    <= '0;
      settle_q <= '0;
      dec_q    <= '0;
      init_q   <= 1'b0;
      vld_p0_q <= 1'b0;
      dlv_p0_q <= 1'b0;
    end else begin
      for (int k = 0; k < ORDER; k++) integ_q[k] <= integ_d[k];
      cnt_q    <= cnt_d;
      settle_q <= settle_d;
      init_q   <= 1'b1;
      if (!init_q || resel) dec_q <= dec_sel;
      vld_p0_q <= wrap && !resel;
      dlv_p0_q <= (settle_q == 3'(ORDER));
    end
  end

  assign comb_x[0] = integ_q[ORDER-1];

  for (genvar k = 0; k < ORDER; k++) begin : g_comb
    cic_comb_stage #(.W(ACC_W)) u_comb (
      .clk   (clk),
      .rst_n (rst_n),
      .clr_i (resel),
      .en_i  (vld_p0_q),
      .x_i   (comb_x[k]),
      .y_o   (comb_x[k+1])
    );
  end

  // Stage p1: capture the comb chain result for the frame just closed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1_q  <= 1'b0;
      comb_p1_q <= '0;
    end else begin
      vld_p1_q <= vld_p0_q && dlv_p0_q;
      if (vld_p0_q) comb_p1_q <= comb_x[ORDER];
    end
  end

  // Stage p2: scaled output register and handshake state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      new_q   <= 1'b0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      new_q <= vld_p1_q;
      if (vld_p1_q) data_q <= sat_out(comb_p1_q, dec_q);
      if (vld_p1_q) begin
        valid_q <= 1'b1;
      end else if (out_if.data_ready) begin
        valid_q <= 1'b0;
      end
      if (vld_p1_q && valid_q && !out_if.data_ready) ovr_q <= 1'b1;
    end
  end

  assign out_if.data_out   = data_q;
  assign out_if.new_data   = new_q;
  assign out_if.data_valid = valid_q;
  assign out_if.overrun    = ovr_q;

endmodule
